color_frame_ctrl: RTL and testbench

Frame-level controller for the color/laser detect core. Gates the upstream pixel stream into the core on software command, tracks x/y position on both sides of the core, and generates SOF (tuser) and EOL (tlast) sidebands downstream. Per frame it reports a laser-hit count and bounding box through a valid/ready result port. It sits between the video source, the detect core and the downstream consumer.

---
 rtl/color_ctrl_pkg.sv | 27 ++
 rtl/color_pix_counter.sv | 56 +++++
 rtl/color_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_color_frame_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_ctrl_pkg.sv
// Shared state encoding, hit marker and width helpers for the color/laser frame controller.
package color_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } ctrl_state_t;

    localparam logic [23:0] HIT_PIXEL_DEF = 24'hFFFFFF;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    function automatic int dim_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    localparam int X_W   = dim_w(IMG_W_DEF);
    localparam int Y_W   = dim_w(IMG_H_DEF);
    localparam int CNT_W = cnt_w(IMG_W_DEF, IMG_H_DEF);

endpackage

// File: rtl/color_pix_counter.sv
// Raster x/y position counter: one step per adv, x wraps into y, y wraps at end of frame.
module color_pix_counter #(
    parameter int W  = 640,
    parameter int H  = 480,
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          first,
    output logic          eol,
    output logic          eof
);
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign first = (x_q == '0) && (y_q == '0);
    assign eol   = (x_q == X_LAST);
    assign eof   = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/color_frame_ctrl.sv
// Frame controller around the color/laser detect core: input gating, SOF/EOL sidebands,
// per-frame hit count and bounding box.
//   state  | meaning
//   IDLE   | input gated, waiting for cfg_start
//   RUN    | input passes to core, output counted
//   DRAIN  | whole frame sent to core, waiting for its last output beat
//   REPORT | result presented on res_*, waiting for res_ready
module color_frame_ctrl import color_ctrl_pkg::*; #(
    parameter int                IMG_W     = IMG_W_DEF,
    parameter int                IMG_H     = IMG_H_DEF,
    parameter int                DATA_W    = 24,
    parameter logic [DATA_W-1:0] HIT_PIXEL = DATA_W'(HIT_PIXEL_DEF)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_start,
    input  logic [7:0]                         cfg_frames,
    input  logic                               cfg_abort,
    output logic                               busy,
    input  logic [DATA_W-1:0]                  s_tdata,
    input  logic                               s_tvalid,
    output logic                               s_tready,
    output logic [DATA_W-1:0]                  c_tdata,
    output logic                               c_tvalid,
    input  logic                               c_tready,
    input  logic [DATA_W-1:0]                  k_tdata,
    input  logic                               k_tvalid,
    output logic                               k_tready,
    output logic [DATA_W-1:0]                  m_tdata,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic                               m_tuser,
    output logic                               m_tlast,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0]   res_hits,
    output logic [$clog2(IMG_W)-1:0]           res_xmin,
    output logic [$clog2(IMG_W)-1:0]           res_xmax,
    output logic [$clog2(IMG_H)-1:0]           res_ymin,
    output logic [$clog2(IMG_H)-1:0]           res_ymax
);
    localparam int XW = dim_w(IMG_W);
    localparam int YW = dim_w(IMG_H);
    localparam int HW = cnt_w(IMG_W, IMG_H);

    ctrl_state_t   state_q, state_d;
    logic [7:0]    frames_q, frames_d;
    logic          cont_q, cont_d;
    logic          busy_q, busy_d;
    logic          res_valid_q, res_valid_d;
    logic [HW-1:0] hits_q, hits_d;
    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

    logic          cnt_clr, run, flowing, in_beat, out_beat, hit;
    logic [XW-1:0] ix, ox;
    logic [YW-1:0] iy, oy;
    logic          in_first, in_eol, in_eof, out_first, out_eol, out_eof;
    logic          unused_in;

    assign run      = (state_q == ST_RUN);
    assign flowing  = run || (state_q == ST_DRAIN);

    // c_tvalid depends only on registered state and s_tvalid, never on c_tready.
    assign c_tdata  = s_tdata;
    assign c_tvalid = run & s_tvalid;
    assign s_tready = run & c_tready;

    assign m_tdata  = k_tdata;
    assign m_tvalid = k_tvalid;
    assign k_tready = m_tready;

    assign in_beat  = run & s_tvalid & c_tready;
    assign out_beat = flowing & k_tvalid & m_tready;
    assign hit      = out_beat & (k_tdata == HIT_PIXEL);
    assign m_tuser  = flowing & out_first;
    assign m_tlast  = flowing & out_eol;

    color_pix_counter #(.W(IMG_W), .H(IMG_H), .XW(XW), .YW(YW)) u_in_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .adv(in_beat),
        .x(ix), .y(iy), .first(in_first), .eol(in_eol), .eof(in_eof)
    );

    color_pix_counter #(.W(IMG_W), .H(IMG_H), .XW(XW), .YW(YW)) u_out_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .adv(out_beat),
        .x(ox), .y(oy), .first(out_first), .eol(out_eol), .eof(out_eof)
    );

    assign unused_in = &{1'b0, in_first, in_eol, ix, iy};

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        cont_d   = cont_q;
        hits_d   = hits_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        cnt_clr  = 1'b0;

        if (hit) begin
            hits_d = hits_q + HW'(1);
            if (hits_q == '0) begin
                xmin_d = ox;
                xmax_d = ox;
                ymin_d = oy;
                ymax_d = oy;
            end else begin
                if (ox < xmin_q) xmin_d = ox;
                if (ox > xmax_q) xmax_d = ox;
                if (oy < ymin_q) ymin_d = oy;
                if (oy > ymax_q) ymax_d = oy;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    frames_d = cfg_frames;
                    cont_d   = (cfg_frames == 8'd0);
                    cnt_clr  = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_beat && in_eof)
                    state_d = (out_beat && out_eof) ? ST_REPORT : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_beat && out_eof) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready) begin
                    cnt_clr = 1'b1;
                    if (cont_q || (frames_q > 8'd1)) begin
                        if (!cont_q) frames_d = frames_q - 8'd1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cfg_abort) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end

        // Accumulators restart together with the raster counters.
        if (cnt_clr) begin
            hits_d = '0;
            xmin_d = '0;
            xmax_d = '0;
            ymin_d = '0;
            ymax_d = '0;
        end

        busy_d      = (state_d != ST_IDLE);
        res_valid_d = (state_d == ST_REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frames_q    <= '0;
            cont_q      <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            hits_q      <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
        end else begin
            state_q     <= state_d;
            frames_q    <= frames_d;
            cont_q      <= cont_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            hits_q      <= hits_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_hits  = hits_q;
    assign res_xmin  = xmin_q;
    assign res_xmax  = xmax_q;
    assign res_ymin  = ymin_q;
    assign res_ymax  = ymax_q;

endmodule

// File: tb/tb_color_frame_ctrl.sv
// Bench for color_frame_ctrl on a 4x2 image with a 1-cycle pass-through core model.
module tb_color_frame_ctrl;
    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;
    localparam logic [23:0] HIT = 24'hFFFFFF;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [3:0] hits;
        logic [1:0] xmin;
        logic [1:0] xmax;
        logic [0:0] ymin;
        logic [0:0] ymax;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [7:0] cfg_frames = 8'd0;
    logic busy;
    logic [23:0] s_tdata, c_tdata, k_tdata, m_tdata;
    logic s_tvalid, s_tready, c_tvalid, c_tready, k_tvalid, k_tready;
    logic m_tvalid, m_tready, m_tuser, m_tlast;
    logic res_valid, res_ready = 1'b1;
    logic [3:0] res_hits;
    logic [1:0] res_xmin, res_xmax;
    logic [0:0] res_ymin, res_ymax;

    int vectors = 0, miscompares = 0, cyc = 0, in_cnt = 0;
    int mready_mode = 0;
    int last_beat_cyc = 0, first_rv_cyc = 0;
    bit rv_seen = 0;
    logic [23:0] src_q[$];
    beat_t beats[$];
    res_t reps[$];

    always #5 clk = ~clk;

    color_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DATA_W(24), .HIT_PIXEL(HIT)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_frames(cfg_frames),
        .cfg_abort(cfg_abort), .busy(busy),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
        .k_tdata(k_tdata), .k_tvalid(k_tvalid), .k_tready(k_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast),
        .res_valid(res_valid), .res_ready(res_ready), .res_hits(res_hits),
        .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin), .res_ymax(res_ymax)
    );

    // Detect core stand-in: one-entry pipeline stage, one cycle of latency.
    logic        core_v;
    logic [23:0] core_d;
    assign c_tready = !core_v || k_tready;
    assign k_tvalid = core_v;
    assign k_tdata  = core_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_v <= 1'b0;
            core_d <= '0;
        end else if (c_tvalid && c_tready) begin
            core_v <= 1'b1;
            core_d <= c_tdata;
        end else if (k_tready) begin
            core_v <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    function automatic res_t model(input logic [23:0] px[N]);
        int h, xmn, xmx, ymn, ymx;
        res_t r;
        h = 0; xmn = W; xmx = 0; ymn = H; ymx = 0;
        for (int i = 0; i < N; i++) begin
            if (px[i] == HIT) begin
                h++;
                xmn = (i % W < xmn) ? i % W : xmn;
                xmx = (i % W > xmx) ? i % W : xmx;
                ymn = (i / W < ymn) ? i / W : ymn;
                ymx = (i / W > ymx) ? i / W : ymx;
            end
        end
        r = '0;
        if (h > 0) begin
            r.hits = 4'(h);
            r.xmin = 2'(xmn);
            r.xmax = 2'(xmx);
            r.ymin = 1'(ymn);
            r.ymax = 1'(ymx);
        end
        return r;
    endfunction

    function automatic beat_t want_beat(input logic [23:0] d, input int k);
        beat_t b;
        b.d = d;
        b.u = ((k % N) == 0);
        b.l = ((k % W) == W - 1);
        return b;
    endfunction

    function automatic res_t cur_res();
        res_t r;
        r.hits = res_hits; r.xmin = res_xmin; r.xmax = res_xmax;
        r.ymin = res_ymin; r.ymax = res_ymax;
        return r;
    endfunction

    task automatic gen_frame(output logic [23:0] px[N], input int hit_pct);
        for (int i = 0; i < N; i++) begin
            px[i] = (int'($urandom_range(0, 99)) < hit_pct) ? HIT : (24'($urandom()) & 24'hFFFFFE);
            src_q.push_back(px[i]);
        end
    endtask

    task automatic drive();
        s_tvalid = (src_q.size() > 0);
        s_tdata  = (src_q.size() > 0) ? src_q[0] : 24'h0;
        m_tready = (mready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    endtask

    // Sample handshakes mid-cycle, then advance drivers just after the rising edge.
    task automatic step();
        bit acc;
        beat_t b;
        @(negedge clk);
        acc = s_tvalid && s_tready;
        if (acc) in_cnt++;
        if (m_tvalid && m_tready) begin
            b.d = m_tdata; b.u = m_tuser; b.l = m_tlast;
            beats.push_back(b);
            last_beat_cyc = cyc;
        end
        if (res_valid && !rv_seen) begin
            rv_seen = 1;
            first_rv_cyc = cyc;
        end
        if (res_valid && res_ready && !cfg_abort) reps.push_back(cur_res());
        @(posedge clk);
        #1;
        cyc++;
        if (acc) void'(src_q.pop_front());
        drive();
    endtask

    task automatic pulse_start(input logic [7:0] frames);
        cfg_start = 1'b1;
        cfg_frames = frames;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic clear_scoreboard();
        src_q.delete(); beats.delete(); reps.delete();
        in_cnt = 0; rv_seen = 0;
        drive();
    endtask

    task automatic test_reset();
        logic [23:0] px[N];
        gen_frame(px, 50);
        drive();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        step();
        vectors++;
        if ({busy, res_valid} !== 2'b00) begin
            miscompares++; $display("FAIL reset_busy_valid: got %b expected 00", {busy, res_valid});
        end
        vectors++;
        if (cur_res() !== res_t'(0)) begin
            miscompares++; $display("FAIL reset_res_fields: got %h expected 0", cur_res());
        end
        vectors++;
        if ({s_tready, c_tvalid, m_tuser, m_tlast} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_stream_ctl: got %b expected 0000", {s_tready, c_tvalid, m_tuser, m_tlast});
        end
        pulse_start(8'd1);
        step(); step();
        vectors++;
        if (busy !== 1'b1 || in_cnt == 0) begin
            miscompares++; $display("FAIL reset_pre_run: busy %b in_cnt %0d expected busy 1 and beats accepted", busy, in_cnt);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, res_valid, s_tready, c_tvalid, m_tuser, m_tlast} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_async: got %b expected 000000", {busy, res_valid, s_tready, c_tvalid, m_tuser, m_tlast});
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (s_tready !== 1'b0 || busy !== 1'b0 || s_tvalid !== 1'b1) begin
                miscompares++; $display("FAIL reset_stays_idle: s_tready %b busy %b expected 0 0", s_tready, busy);
            end
        end
        clear_scoreboard();
    endtask

    task automatic test_single_frame();
        logic [23:0] px[N];
        res_t want;
        clear_scoreboard();
        for (int i = 0; i < N; i++) begin
            px[i] = (i == 1 || i == 6) ? HIT : (24'($urandom()) & 24'hFFFFFE);
            src_q.push_back(px[i]);
        end
        want = '{hits: 4'd2, xmin: 2'd1, xmax: 2'd2, ymin: 1'd0, ymax: 1'd1};
        res_ready = 1'b1;
        pulse_start(8'd1);
        for (int t = 0; t < 100 && reps.size() < 1; t++) step();
        vectors++;
        if (reps.size() != 1) begin
            miscompares++; $display("FAIL single_report_count: got %0d expected 1", reps.size());
        end else if (reps[0] !== want) begin
            miscompares++; $display("FAIL single_result: got %h expected %h", reps[0], want);
        end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (k >= beats.size() || beats[k] !== want_beat(px[k], k)) begin
                miscompares++;
                $display("FAIL single_beat %0d: got %h expected %h", k,
                         (k < beats.size()) ? beats[k] : beat_t'(0), want_beat(px[k], k));
            end
        end
        vectors++;
        if (first_rv_cyc != last_beat_cyc + 1) begin
            miscompares++; $display("FAIL single_rv_latency: got cycle %0d expected %0d", first_rv_cyc, last_beat_cyc + 1);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL single_idle_after: busy %b expected 0", busy);
        end
    endtask

    task automatic test_hold();
        logic [23:0] px0[N], px1[N];
        res_t want0;
        bit ok;
        clear_scoreboard();
        gen_frame(px0, 0);
        gen_frame(px1, 0);
        want0 = model(px0);
        res_ready = 1'b0;
        pulse_start(8'd2);
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin step(); ok = res_valid; end
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL hold_first_valid: res_valid never rose, expected 1");
        end
        for (int h = 0; h < 5; h++) begin
            vectors++;
            if (res_valid !== 1'b1 || cur_res() !== want0 || s_tready !== 1'b0 || in_cnt != N) begin
                miscompares++;
                $display("FAIL hold_stable %0d: valid %b res %h s_tready %b in %0d expected 1 %h 0 %0d",
                         h, res_valid, cur_res(), s_tready, in_cnt, want0, N);
            end
            step();
        end
        res_ready = 1'b1;
        for (int t = 0; t < 100 && (reps.size() < 2 || busy); t++) step();
        vectors++;
        if (reps.size() != 2) begin
            miscompares++; $display("FAIL hold_report_count: got %0d expected 2", reps.size());
        end else if (reps[0] !== want0 || reps[1] !== model(px1)) begin
            miscompares++; $display("FAIL hold_results: got %h %h expected %h %h", reps[0], reps[1], want0, model(px1));
        end
        vectors++;
        if (busy !== 1'b0 || beats.size() != 2 * N) begin
            miscompares++; $display("FAIL hold_end: busy %b beats %0d expected 0 %0d", busy, beats.size(), 2 * N);
        end
    endtask

    task automatic test_mready_toggle();
        logic [23:0] px[N];
        clear_scoreboard();
        gen_frame(px, 40);
        mready_mode = 1;
        res_ready = 1'b1;
        pulse_start(8'd1);
        for (int t = 0; t < 200 && reps.size() < 1; t++) step();
        mready_mode = 0;
        vectors++;
        if (reps.size() != 1 || reps[0] !== model(px)) begin
            miscompares++;
            $display("FAIL toggle_result: got %0d reports first %h expected 1 report %h",
                     reps.size(), (reps.size() > 0) ? reps[0] : res_t'(0), model(px));
        end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (k >= beats.size() || beats[k] !== want_beat(px[k], k)) begin
                miscompares++;
                $display("FAIL toggle_beat %0d: got %h expected %h", k,
                         (k < beats.size()) ? beats[k] : beat_t'(0), want_beat(px[k], k));
            end
        end
        vectors++;
        if (first_rv_cyc != last_beat_cyc + 1 || beats.size() != N) begin
            miscompares++;
            $display("FAIL toggle_drain_end: res_valid cycle %0d beats %0d expected cycle %0d beats %0d",
                     first_rv_cyc, beats.size(), last_beat_cyc + 1, N);
        end
    endtask

    task automatic test_abort();
        logic [23:0] px[N];
        int held_in;
        clear_scoreboard();
        gen_frame(px, 50);
        res_ready = 1'b1;
        pulse_start(8'd1);
        for (int t = 0; t < 50 && in_cnt < 5; t++) step();
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        vectors++;
        if ({busy, res_valid, s_tready} !== 3'b000) begin
            miscompares++; $display("FAIL abort_idle: busy/valid/s_tready %b expected 000", {busy, res_valid, s_tready});
        end
        held_in = in_cnt;
        for (int t = 0; t < 20; t++) step();
        vectors++;
        if (rv_seen || busy !== 1'b0 || in_cnt != held_in) begin
            miscompares++;
            $display("FAIL abort_quiet: res_valid seen %0d busy %b in %0d expected 0 0 %0d", rv_seen, busy, in_cnt, held_in);
        end
        clear_scoreboard();
        gen_frame(px, 50);
        pulse_start(8'd1);
        for (int t = 0; t < 100 && reps.size() < 1; t++) step();
        vectors++;
        if (reps.size() != 1 || reps[0] !== model(px)) begin
            miscompares++;
            $display("FAIL abort_clean_frame: got %0d reports first %h expected 1 report %h",
                     reps.size(), (reps.size() > 0) ? reps[0] : res_t'(0), model(px));
        end
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (k >= beats.size() || beats[k] !== want_beat(px[k], k)) begin
                miscompares++;
                $display("FAIL abort_clean_beat %0d: got %h expected %h", k,
                         (k < beats.size()) ? beats[k] : beat_t'(0), want_beat(px[k], k));
            end
        end
        // Abort during REPORT must win over a same-cycle res_ready.
        clear_scoreboard();
        gen_frame(px, 50);
        res_ready = 1'b0;
        pulse_start(8'd2);
        for (int t = 0; t < 100 && !res_valid; t++) step();
        cfg_abort = 1'b1;
        res_ready = 1'b1;
        step();
        cfg_abort = 1'b0;
        vectors++;
        if ({busy, res_valid} !== 2'b00 || reps.size() != 0) begin
            miscompares++;
            $display("FAIL abort_in_report: busy/valid %b reports %0d expected 00 0", {busy, res_valid}, reps.size());
        end
        for (int t = 0; t < 5; t++) step();
        clear_scoreboard();
    endtask

    task automatic test_start_in_run();
        logic [23:0] px0[N], px1[N];
        clear_scoreboard();
        gen_frame(px0, 30);
        gen_frame(px1, 30);
        res_ready = 1'b1;
        pulse_start(8'd2);
        step(); step();
        pulse_start(8'd5);
        for (int t = 0; t < 300 && (reps.size() < 2 || busy); t++) step();
        vectors++;
        if (reps.size() != 2 || busy !== 1'b0) begin
            miscompares++; $display("FAIL start_in_run_count: reports %0d busy %b expected 2 0", reps.size(), busy);
        end else if (reps[0] !== model(px0) || reps[1] !== model(px1)) begin
            miscompares++;
            $display("FAIL start_in_run_results: got %h %h expected %h %h", reps[0], reps[1], model(px0), model(px1));
        end
        for (int k = 0; k < 2 * N; k++) begin
            vectors++;
            if (k >= beats.size() || beats[k] !== want_beat((k < N) ? px0[k] : px1[k - N], k)) begin
                miscompares++;
                $display("FAIL start_in_run_beat %0d: got %h expected %h", k,
                         (k < beats.size()) ? beats[k] : beat_t'(0), want_beat((k < N) ? px0[k] : px1[k - N], k));
            end
        end
    endtask

    initial begin
        drive();
        test_reset();
        test_single_frame();
        test_hold();
        test_mready_toggle();
        test_abort();
        test_start_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
